ncc_feeder: RTL and testbench
=============================

// Module: ncc_feeder
// PURPOSE
//  Initiator side of the NCC matcher load interface. Buffers one 16x16 descriptor from an upstream
//  4-pixel/word stream, then replays it as 64 back-to-back desc words with desc_data_ready held high.
//  Assembles successive 16x16 search windows from the same stream and presents each one with a
//  one-cycle window_data_ready pulse. Waits for the matcher's done_* acknowledgements between loads.
//  Sits between the frame/DMA reader and ncc.
// PARAMETERS
//  PIX_W      9    signed pixel width
//  LANES      4    pixels per stream/desc word
//  WIN_DIM    16   window/descriptor edge length
//  NWIN_W     9    width of window count (matches matcher window index)
// PORTS
//  clk                   in   1                      clock
//  rst                   in   1                      sync active-high reset
//  start                 in   1                      pulse: begin job (sampled in IDLE only)
//  num_windows           in   NWIN_W                 windows in job, sampled with start
//  pix_in                in   LANES*PIX_W (36)       stream word; [35:27]=lowest column of the group
//  pix_valid             in   1                      pix_in valid
//  pix_ready             out  1                      feeder accepts pix_in this cycle
//  desc_out              out  LANES*PIX_W            descriptor word to matcher
//  desc_data_ready       out  1                      desc_out valid; high 64 consecutive cycles
//  done_with_desc_data   in   1                      matcher consumed descriptor
//  win_out               out  WIN_DIM*WIN_DIM*PIX_W  window; elem[r][c] at ((r*WIN_DIM+c)*PIX_W)+:PIX_W
//  window_data_ready     out  1                      one-cycle pulse, win_out valid
//  done_with_window_data in   1                      matcher consumed window
//  busy                  out  1                      job in progress
//  job_done              out  1                      one-cycle pulse after last window acked
// BEHAVIOUR
//  Reset: state=IDLE; pix_ready, desc_data_ready, window_data_ready, busy, job_done = 0.
//   desc_out, win_out, buffers and counters = 0. Reset mid-job aborts; no partial load resumes.
//  Transfer: a stream word moves iff pix_valid && pix_ready. Gaps in pix_valid are allowed.
//   pix_ready=1 only in DESC_FILL and WIN_FILL.
//  Word k (0..63) -> row k/4, cols 4*(k%4)+0..3; pix_in[35:27]->col+0 ... [8:0]->col+3.
//  States:
//   IDLE: start -> DESC_FILL; latch num_windows; busy=1 next cycle.
//    start outside IDLE is ignored.
//   DESC_FILL: store 64 words in 64x36 buffer. After word 63 -> DESC_LOAD.
//   DESC_LOAD: for 64 consecutive cycles, desc_data_ready=1 and desc_out=buf[i], i=0..63.
//    Cycles are never stalled. Then desc_data_ready=0 -> DESC_WAIT.
//   DESC_WAIT: done_with_desc_data -> WIN_FILL, or FINISH if num_windows==0.
//   WIN_FILL: write words into the window register. After word 63 -> WIN_PULSE.
//   WIN_PULSE: window_data_ready=1 for exactly one cycle -> WIN_WAIT.
//   WIN_WAIT: win_out held stable. On done_with_window_data, decrement the remaining count;
//    remaining==0 -> FINISH, else -> WIN_FILL.
//   FINISH: job_done=1 one cycle; busy=0 next cycle; -> IDLE.
//  done_* inputs are ignored outside their WAIT state; an early ack is not remembered.
//  win_out is only overwritten in WIN_FILL. desc_out keeps its last word after DESC_LOAD.
//  Min latency start->first window_data_ready (pix_valid=1 always):
//   64 fill + 64 load + ack + 64 fill + 1.
//  All counters are 6-bit word counters that wrap 63->0 on the exit transition.
//  The window count is unsigned; num_windows up to 2^NWIN_W-1.
// TESTING
//  1: start, num_windows=1, 64 words of {30,40,50,60}
//   -> desc_data_ready high exactly 64 cycles, every desc_out=={30,40,50,60}.
//  2: then done_with_desc_data, 64 words all 2
//   -> one window_data_ready pulse, all 256 win_out elems==2;
//   ack -> job_done pulse, busy=0.
//  3: num_windows=3, word k = {4k,4k+1,4k+2,4k+3} (mod 256 signed)
//   -> elem[r][c]==16r+c for each of 3 windows; 3 pulses; job_done after 3rd ack.
//  4: pix_valid toggled randomly 50% and delayed acks (0-20 cycles)
//   -> same data as scenario 3, desc_data_ready never gaps, win_out stable in WIN_WAIT.
//  5: acks asserted early (in DESC_FILL/WIN_FILL) and start while busy -> ignored, no state skip.
//   num_windows=0 -> job_done right after desc ack, no window pulse.
//  6: rst asserted mid WIN_FILL -> next cycle all outputs 0, IDLE.
//   A new start runs scenario 1 cleanly.

Source files
------------

// File: rtl/ncc_feeder_if.sv
// Load-side bundle between the frame/DMA feeder and the NCC matcher.
// master = feeder (drives pix_ready, desc/window data); slave = stream source + matcher.
interface ncc_feeder_if #(
  parameter int PIX_W   = 9,
  parameter int LANES   = 4,
  parameter int WIN_DIM = 16,
  parameter int NWIN_W  = 9
);
  localparam int WORD_W = LANES * PIX_W;
  localparam int WIN_W  = WIN_DIM * WIN_DIM * PIX_W;

  logic              start;
  logic [NWIN_W-1:0] num_windows;
  logic [WORD_W-1:0] pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [WORD_W-1:0] desc_out;
  logic              desc_data_ready;
  logic              done_with_desc_data;
  logic [WIN_W-1:0]  win_out;
  logic              window_data_ready;
  logic              done_with_window_data;
  logic              busy;
  logic              job_done;

  modport master (
    input  start, num_windows, pix_in, pix_valid, done_with_desc_data, done_with_window_data,
    output pix_ready, desc_out, desc_data_ready, win_out, window_data_ready, busy, job_done
  );

  modport slave (
    output start, num_windows, pix_in, pix_valid, done_with_desc_data, done_with_window_data,
    input  pix_ready, desc_out, desc_data_ready, win_out, window_data_ready, busy, job_done
  );
endinterface

// File: rtl/ncc_feeder.sv
// NCC matcher feeder: buffers one descriptor, replays it as a 64-cycle burst, then
// assembles and presents each search window, pacing itself on the matcher's acks.
module ncc_feeder #(
  parameter int PIX_W   = 9,
  parameter int LANES   = 4,
  parameter int WIN_DIM = 16,
  parameter int NWIN_W  = 9
) (
  input  logic          clk,
  input  logic          rst,
  ncc_feeder_if.master  bus
);
  localparam int WORD_W = LANES * PIX_W;
  localparam int NWORDS = WIN_DIM * WIN_DIM / LANES;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam int WIN_W  = WIN_DIM * WIN_DIM * PIX_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE, DESC_FILL, DESC_LOAD, DESC_WAIT, WIN_FILL, WIN_PULSE, WIN_WAIT, FINISH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NWIN_W-1:0]  remaining;
  logic [WORD_W-1:0]  desc_buf [NWORDS];
  logic [WORD_W-1:0]  desc_q;
  logic [WIN_W-1:0]   win_q;
  logic               pix_ready_q;
  logic               desc_rdy_q;
  logic               win_rdy_q;
  logic               busy_q;
  logic               job_done_q;
  logic               take;

  assign take = bus.pix_valid && pix_ready_q;

  // Lane 0 sits in the top bits of the stream word and maps to the lowest column.
  function automatic logic signed [PIX_W-1:0] lane_pix(input logic [WORD_W-1:0] word,
                                                       input int lane);
    return $signed(word[(LANES-1-lane)*PIX_W +: PIX_W]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      remaining   <= '0;
      desc_q      <= '0;
      win_q       <= '0;
      pix_ready_q <= 1'b0;
      desc_rdy_q  <= 1'b0;
      win_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      for (int i = 0; i < NWORDS; i++) desc_buf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= DESC_FILL;
            remaining   <= bus.num_windows;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt         <= '0;
          end
        end
        DESC_FILL: begin
          if (take) begin
            desc_buf[cnt] <= bus.pix_in;
            cnt           <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state       <= DESC_LOAD;
              pix_ready_q <= 1'b0;
              desc_rdy_q  <= 1'b1;
              desc_q      <= desc_buf[0];
            end
          end
        end
        // cnt indexes the word currently on desc_out; the burst never stalls.
        DESC_LOAD: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            desc_rdy_q <= 1'b0;
            state      <= DESC_WAIT;
          end else begin
            desc_q <= desc_buf[cnt + CNT_W'(1)];
          end
        end
        DESC_WAIT: begin
          if (bus.done_with_desc_data) begin
            if (remaining == '0) begin
              state      <= FINISH;
              job_done_q <= 1'b1;
            end else begin
              state       <= WIN_FILL;
              pix_ready_q <= 1'b1;
            end
          end
        end
        WIN_FILL: begin
          if (take) begin
            for (int j = 0; j < LANES; j++)
              win_q[(int'(cnt)*LANES + j)*PIX_W +: PIX_W] <= lane_pix(bus.pix_in, j);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state       <= WIN_PULSE;
              pix_ready_q <= 1'b0;
              win_rdy_q   <= 1'b1;
            end
          end
        end
        WIN_PULSE: begin
          win_rdy_q <= 1'b0;
          state     <= WIN_WAIT;
        end
        WIN_WAIT: begin
          if (bus.done_with_window_data) begin
            remaining <= remaining - NWIN_W'(1);
            if (remaining == NWIN_W'(1)) begin
              state      <= FINISH;
              job_done_q <= 1'b1;
            end else begin
              state       <= WIN_FILL;
              pix_ready_q <= 1'b1;
            end
          end
        end
        FINISH: begin
          job_done_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready         = pix_ready_q;
  assign bus.desc_out          = desc_q;
  assign bus.desc_data_ready   = desc_rdy_q;
  assign bus.win_out           = win_q;
  assign bus.window_data_ready = win_rdy_q;
  assign bus.busy              = busy_q;
  assign bus.job_done          = job_done_q;
endmodule

// File: tb/tb_ncc_feeder.sv
// Randomized self-checking bench for ncc_feeder: a stream/matcher driver records what the
// feeder presents, and each scenario task compares that record against a row/column model.
module tb_ncc_feeder;
  localparam int PIX_W   = 9;
  localparam int LANES   = 4;
  localparam int WIN_DIM = 16;
  localparam int NWIN_W  = 9;
  localparam int WORD_W  = LANES * PIX_W;
  localparam int WB      = WIN_DIM * WIN_DIM * PIX_W;
  localparam int NWORDS  = WIN_DIM * WIN_DIM / LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ncc_feeder_if #(.PIX_W(PIX_W), .LANES(LANES), .WIN_DIM(WIN_DIM), .NWIN_W(NWIN_W)) bus ();

  ncc_feeder #(.PIX_W(PIX_W), .LANES(LANES), .WIN_DIM(WIN_DIM), .NWIN_W(NWIN_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WORD_W-1:0] stream [$];
  logic [WORD_W-1:0] r_desc_q [$];
  logic [WB-1:0]     r_win_q [$];
  int                r_desc_gaps, r_unstable, r_jobdone, r_words;
  logic              r_busy_after, r_ready_after, r_timeout;
  logic [WORD_W-1:0] r_desc_last;

  localparam logic [WORD_W-1:0] CONST_DESC = {9'd30, 9'd40, 9'd50, 9'd60};
  localparam logic [WORD_W-1:0] CONST_TWO  = {9'd2, 9'd2, 9'd2, 9'd2};

  function automatic logic [WORD_W-1:0] ramp_word(input int k);
    logic [WORD_W-1:0] w;
    w = {PIX_W'(4*k), PIX_W'(4*k+1), PIX_W'(4*k+2), PIX_W'(4*k+3)};
    return w;
  endfunction

  // Window model: elem[r][c] comes from word (r*16+c)/4, lane c%4, lane 0 = top bits.
  function automatic logic [WB-1:0] model_win(input int base);
    logic [WB-1:0]     v;
    logic [WORD_W-1:0] w;
    int                lane;
    v = '0;
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM; c++) begin
        w    = stream[base + (r*WIN_DIM + c) / LANES];
        lane = c % LANES;
        v[(r*WIN_DIM + c)*PIX_W +: PIX_W] = w[WORD_W-1-lane*PIX_W -: PIX_W];
      end
    return v;
  endfunction

  function automatic logic [WB-1:0] ramp_win();
    logic [WB-1:0] v;
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM; c++)
        v[(r*WIN_DIM + c)*PIX_W +: PIX_W] = PIX_W'(16*r + c);
    return v;
  endfunction

  function automatic int first_diff(input logic [WB-1:0] a, input logic [WB-1:0] b);
    for (int i = 0; i < WIN_DIM*WIN_DIM; i++)
      if (a[i*PIX_W +: PIX_W] !== b[i*PIX_W +: PIX_W]) return i;
    return -1;
  endfunction

  task automatic push_words(input int n, input int kind, input logic [WORD_W-1:0] cw);
    for (int k = 0; k < n; k++)
      case (kind)
        0:       stream.push_back(cw);
        1:       stream.push_back(ramp_word(k));
        default: stream.push_back(WORD_W'({$urandom, $urandom}));
      endcase
  endtask

  // Drives one job: stream source with pix_valid at vpct %, acks after 0..maxd idle cycles.
  task automatic drive_job(input int nwin, input int vpct, input int maxd,
                           input bit early, input int abort_words);
    int            idx = 0;
    int            dly_d = 0;
    int            dly_w = 0;
    bit            xfer, desc_ended = 0, ack_d = 0, in_ww = 0, fin = 0;
    logic [WB-1:0] hold = '0;
    r_desc_q.delete();
    r_win_q.delete();
    r_desc_gaps = 0; r_unstable = 0; r_jobdone = 0; r_timeout = 1'b1;
    bus.num_windows = NWIN_W'(nwin);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.num_windows = NWIN_W'($urandom);
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (fin || (abort_words >= 0 && idx >= NWORDS + abort_words)) begin
        r_timeout = 1'b0;
        break;
      end
      if (bus.desc_data_ready) begin
        if (desc_ended) r_desc_gaps++;
        r_desc_q.push_back(bus.desc_out);
      end else if (r_desc_q.size() > 0 && !desc_ended) begin
        desc_ended = 1; ack_d = 1; dly_d = int'($urandom_range(maxd, 0));
      end
      if (bus.window_data_ready) begin
        r_win_q.push_back(bus.win_out);
        hold = bus.win_out; in_ww = 1; dly_w = int'($urandom_range(maxd, 0));
      end else if (in_ww && bus.win_out !== hold) r_unstable++;
      if (bus.job_done) begin r_jobdone++; fin = 1; end

      bus.done_with_desc_data   = 1'b0;
      bus.done_with_window_data = 1'b0;
      if (ack_d) begin
        if (dly_d == 0) begin bus.done_with_desc_data = 1'b1; ack_d = 0; end
        else dly_d--;
      end
      if (in_ww && !bus.window_data_ready) begin
        if (dly_w == 0) begin bus.done_with_window_data = 1'b1; in_ww = 0; end
        else dly_w--;
      end
      if (early && bus.pix_ready && $urandom_range(3, 0) == 0) begin
        bus.done_with_desc_data   = 1'b1;
        bus.done_with_window_data = 1'b1;
      end
      bus.start     = early && bus.busy && ($urandom_range(7, 0) == 0);
      bus.pix_valid = (idx < stream.size()) && ($urandom_range(99, 0) < vpct);
      bus.pix_in    = bus.pix_valid ? stream[idx] : WORD_W'({$urandom, $urandom});
      xfer          = bus.pix_valid && bus.pix_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
    end
    bus.start = 1'b0; bus.pix_valid = 1'b0;
    bus.done_with_desc_data = 1'b0; bus.done_with_window_data = 1'b0;
    r_words = idx; r_busy_after = bus.busy; r_ready_after = bus.pix_ready;
    r_desc_last = bus.desc_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.pix_ready, bus.desc_data_ready, bus.window_data_ready, bus.busy, bus.job_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 00000", {bus.pix_ready, bus.desc_data_ready,
               bus.window_data_ready, bus.busy, bus.job_done});
    end
    n_cmp++;
    if (bus.desc_out !== '0 || bus.win_out !== '0) begin
      n_bad++;
      $display("FAIL reset_data: desc_out=%h win_out nonzero=%0d required all zero",
               bus.desc_out, bus.win_out !== '0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_window();
    int bad = 0;
    logic [WB-1:0] exp_w;
    stream.delete();
    push_words(NWORDS, 0, CONST_DESC);
    push_words(NWORDS, 0, CONST_TWO);
    drive_job(1, 100, 0, 0, -1);
    for (int k = 0; k < r_desc_q.size(); k++) if (r_desc_q[k] !== CONST_DESC) bad++;
    for (int i = 0; i < WIN_DIM*WIN_DIM; i++) exp_w[i*PIX_W +: PIX_W] = 9'sd2;
    n_cmp++;
    if (r_timeout !== 1'b0) begin n_bad++; $display("FAIL single_timeout: job did not finish"); end
    n_cmp++;
    if (r_desc_q.size() != NWORDS || r_desc_gaps != 0) begin
      n_bad++; $display("FAIL single_desc_len: got %0d cycles %0d gaps required 64/0", r_desc_q.size(), r_desc_gaps);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL single_desc_data: got %0d bad words required 0", bad); end
    n_cmp++;
    if (r_win_q.size() != 1) begin n_bad++; $display("FAIL single_pulses: got %0d required 1", r_win_q.size()); end
    else begin
      n_cmp++;
      if (r_win_q[0] !== exp_w) begin
        n_bad++; $display("FAIL single_win_data: elem %0d got %0d required 2", first_diff(r_win_q[0], exp_w),
                          $signed(r_win_q[0][first_diff(r_win_q[0], exp_w)*PIX_W +: PIX_W]));
      end
    end
    n_cmp++;
    if (r_jobdone != 1 || r_busy_after !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got job_done=%0d busy_after=%b required 1/0", r_jobdone, r_busy_after);
    end
    n_cmp++;
    if (r_desc_last !== CONST_DESC) begin
      n_bad++; $display("FAIL single_desc_hold: got %h required %h", r_desc_last, CONST_DESC);
    end
  endtask

  task automatic test_ramp_windows(input int vpct, input int maxd);
    int bad = 0;
    stream.delete();
    for (int w = 0; w < 4; w++) push_words(NWORDS, 1, '0);
    drive_job(3, vpct, maxd, 0, -1);
    for (int k = 0; k < r_desc_q.size(); k++) if (r_desc_q[k] !== ramp_word(k)) bad++;
    n_cmp++;
    if (r_timeout !== 1'b0 || r_words != 4*NWORDS) begin
      n_bad++; $display("FAIL ramp_words(v%0d): got %0d words timeout=%b required 256/0", vpct, r_words, r_timeout);
    end
    n_cmp++;
    if (r_desc_q.size() != NWORDS || r_desc_gaps != 0 || bad != 0) begin
      n_bad++; $display("FAIL ramp_desc(v%0d): got len %0d gaps %0d bad %0d required 64/0/0",
                        vpct, r_desc_q.size(), r_desc_gaps, bad);
    end
    n_cmp++;
    if (r_win_q.size() != 3) begin n_bad++; $display("FAIL ramp_pulses(v%0d): got %0d required 3", vpct, r_win_q.size()); end
    foreach (r_win_q[w]) begin
      n_cmp++;
      if (r_win_q[w] !== ramp_win()) begin
        n_bad++; $display("FAIL ramp_win%0d(v%0d): first bad elem %0d got %0d required %0d", w, vpct,
                          first_diff(r_win_q[w], ramp_win()),
                          r_win_q[w][first_diff(r_win_q[w], ramp_win())*PIX_W +: PIX_W],
                          first_diff(r_win_q[w], ramp_win()));
      end
    end
    n_cmp++;
    if (r_unstable != 0) begin n_bad++; $display("FAIL ramp_hold(v%0d): got %0d changes in WIN_WAIT required 0", vpct, r_unstable); end
    n_cmp++;
    if (r_jobdone != 1 || r_busy_after !== 1'b0 || r_ready_after !== 1'b0) begin
      n_bad++; $display("FAIL ramp_done(v%0d): got job_done=%0d busy=%b ready=%b required 1/0/0",
                        vpct, r_jobdone, r_busy_after, r_ready_after);
    end
  endtask

  task automatic test_random_data();
    int bad = 0;
    stream.delete();
    push_words(3*NWORDS, 2, '0);
    drive_job(2, 60, 5, 0, -1);
    for (int k = 0; k < r_desc_q.size(); k++) if (r_desc_q[k] !== stream[k]) bad++;
    n_cmp++;
    if (r_desc_q.size() != NWORDS || bad != 0) begin
      n_bad++; $display("FAIL rand_desc: got len %0d bad %0d required 64/0", r_desc_q.size(), bad);
    end
    n_cmp++;
    if (r_win_q.size() != 2 || r_jobdone != 1) begin
      n_bad++; $display("FAIL rand_pulses: got %0d pulses %0d done required 2/1", r_win_q.size(), r_jobdone);
    end
    foreach (r_win_q[w]) begin
      n_cmp++;
      if (r_win_q[w] !== model_win(NWORDS*(w+1))) begin
        n_bad++; $display("FAIL rand_win%0d: first bad elem %0d got %h required %h", w,
                          first_diff(r_win_q[w], model_win(NWORDS*(w+1))),
                          r_win_q[w][first_diff(r_win_q[w], model_win(NWORDS*(w+1)))*PIX_W +: PIX_W],
                          model_win(NWORDS*(w+1))[first_diff(r_win_q[w], model_win(NWORDS*(w+1)))*PIX_W +: PIX_W]);
      end
    end
  endtask

  task automatic test_early_and_zero();
    int bad = 0;
    stream.delete();
    for (int w = 0; w < 3; w++) push_words(NWORDS, 1, '0);
    drive_job(2, 70, 4, 1, -1);
    n_cmp++;
    if (r_timeout !== 1'b0 || r_words != 3*NWORDS || r_win_q.size() != 2 || r_jobdone != 1) begin
      n_bad++; $display("FAIL early_flow: got words %0d pulses %0d done %0d required 192/2/1",
                        r_words, r_win_q.size(), r_jobdone);
    end
    foreach (r_win_q[w]) begin
      n_cmp++;
      if (r_win_q[w] !== ramp_win()) begin
        n_bad++; $display("FAIL early_win%0d: first bad elem %0d", w, first_diff(r_win_q[w], ramp_win()));
      end
    end
    n_cmp++;
    if (r_desc_q.size() != NWORDS || r_desc_gaps != 0) begin
      n_bad++; $display("FAIL early_desc: got len %0d gaps %0d required 64/0", r_desc_q.size(), r_desc_gaps);
    end
    stream.delete();
    push_words(2*NWORDS, 2, '0);
    drive_job(0, 80, 3, 1, -1);
    for (int k = 0; k < r_desc_q.size(); k++) if (r_desc_q[k] !== stream[k]) bad++;
    n_cmp++;
    if (r_win_q.size() != 0 || r_jobdone != 1 || r_words != NWORDS || r_busy_after !== 1'b0) begin
      n_bad++; $display("FAIL zero_win: got pulses %0d done %0d words %0d busy %b required 0/1/64/0",
                        r_win_q.size(), r_jobdone, r_words, r_busy_after);
    end
    n_cmp++;
    if (r_desc_q.size() != NWORDS || bad != 0) begin
      n_bad++; $display("FAIL zero_desc: got len %0d bad %0d required 64/0", r_desc_q.size(), bad);
    end
  endtask

  task automatic test_reset_midjob();
    stream.delete();
    push_words(2*NWORDS, 2, '0);
    drive_job(1, 100, 0, 0, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.pix_ready, bus.desc_data_ready, bus.window_data_ready, bus.busy, bus.job_done} !== 5'b0
        || bus.desc_out !== '0 || bus.win_out !== '0) begin
      n_bad++; $display("FAIL midjob_reset: got flags %b desc %h required all zero", {bus.pix_ready,
               bus.desc_data_ready, bus.window_data_ready, bus.busy, bus.job_done}, bus.desc_out);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
      n_bad++; $display("FAIL midjob_idle: got busy %b ready %b required 0/0", bus.busy, bus.pix_ready);
    end
    test_single_window();
  endtask

  initial begin
    bus.start = 1'b0; bus.num_windows = '0; bus.pix_in = '0; bus.pix_valid = 1'b0;
    bus.done_with_desc_data = 1'b0; bus.done_with_window_data = 1'b0;
    test_reset();
    test_single_window();
    test_ramp_windows(100, 0);
    test_ramp_windows(50, 20);
    test_random_data();
    test_early_and_zero();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
